axis_rr_arbiter: RTL and testbench

AXIS_RR_ARBITER -- requirements
Module: axis_rr_arbiter

---
 rtl/axis_rr_arbiter.sv | 107 ++++++++++
 tb/tb_axis_rr_arbiter.sv | 374 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_rr_arbiter.sv
// Two-slave AXI-Stream round-robin arbiter. A granted slave keeps the master
// port until its TLAST beat transfers; ties go to the slave that did not own last.
module axis_rr_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  ACLK,
    input  logic                  ARESETn,
    input  logic [DATA_WIDTH-1:0] TDATA_in_0,
    input  logic                  TVALID_in_0,
    input  logic                  TLAST_in_0,
    output logic                  TREADY_in_0,
    input  logic [DATA_WIDTH-1:0] TDATA_in_1,
    input  logic                  TVALID_in_1,
    input  logic                  TLAST_in_1,
    output logic                  TREADY_in_1,
    output logic [DATA_WIDTH-1:0] DATA_out,
    output logic                  TVALID_out,
    output logic                  TLAST_out,
    input  logic                  TREADY_out,
    output logic [1:0]            grant,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_0,
    output logic [CNT_WIDTH-1:0]  pkt_cnt_1
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT0,
        GRANT1
    } state_t;

    state_t state;
    state_t next_state;
    logic   last_owner;
    logic   done_0;
    logic   done_1;

    // last_owner resets to 1 so that slave 0 wins the very first tie.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            pkt_cnt_0  <= '0;
            pkt_cnt_1  <= '0;
        end else begin
            state <= next_state;
            if (done_0) begin
                last_owner <= 1'b0;
                pkt_cnt_0  <= pkt_cnt_0 + 1'b1;
            end
            if (done_1) begin
                last_owner <= 1'b1;
                pkt_cnt_1  <= pkt_cnt_1 + 1'b1;
            end
        end
    end

    always_comb begin
        next_state  = state;
        DATA_out    = '0;
        TVALID_out  = 1'b0;
        TLAST_out   = 1'b0;
        TREADY_in_0 = 1'b0;
        TREADY_in_1 = 1'b0;
        grant       = 2'b00;
        done_0      = 1'b0;
        done_1      = 1'b0;

        case (state)
            IDLE: begin
                if (TVALID_in_0 && TVALID_in_1) begin
                    next_state = last_owner ? GRANT0 : GRANT1;
                end else if (TVALID_in_0) begin
                    next_state = GRANT0;
                end else if (TVALID_in_1) begin
                    next_state = GRANT1;
                end
            end
            GRANT0: begin
                DATA_out    = TDATA_in_0;
                TVALID_out  = TVALID_in_0;
                TLAST_out   = TLAST_in_0;
                TREADY_in_0 = TREADY_out;
                grant       = 2'b01;
                done_0      = TVALID_in_0 && TREADY_out && TLAST_in_0;
                if (done_0) begin
                    next_state = IDLE;
                end
            end
            GRANT1: begin
                DATA_out    = TDATA_in_1;
                TVALID_out  = TVALID_in_1;
                TLAST_out   = TLAST_in_1;
                TREADY_in_1 = TREADY_out;
                grant       = 2'b10;
                done_1      = TVALID_in_1 && TREADY_out && TLAST_in_1;
                if (done_1) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_axis_rr_arbiter.sv
// Scoreboard bench for axis_rr_arbiter: directed scenarios plus randomized traffic
// checked against a packet-level round-robin reference model.
module tb_axis_rr_arbiter;

    localparam int DW = 8;
    localparam int CW = 8;

    localparam logic [1:0] TIE_TRACE [17] = '{
        2'b00, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b10, 2'b10,
        2'b10, 2'b10, 2'b00, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00
    };
    localparam logic [1:0] BUBBLE_TRACE [6] = '{
        2'b00, 2'b00, 2'b01, 2'b00, 2'b01, 2'b00
    };

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            gap;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic [DW-1:0] tdata [2];
    logic          tvalid [2];
    logic          tlast [2];
    logic          TREADY_in_0;
    logic          TREADY_in_1;
    logic [DW-1:0] DATA_out;
    logic          TVALID_out;
    logic          TLAST_out;
    logic          TREADY_out;
    logic [1:0]    grant;
    logic [CW-1:0] pkt_cnt_0;
    logic [CW-1:0] pkt_cnt_1;

    int checks = 0;
    int errors = 0;

    beat_t src_q0 [$];
    beat_t src_q1 [$];
    beat_t exp_q0 [$];
    beat_t exp_q1 [$];

    bit started [2];
    int gap_left [2];
    bit acc [2];

    // Reference model: owner is -1 when nobody holds the master port.
    int m_owner = -1;
    int m_last  = 1;
    int m_cnt [2];

    axis_rr_arbiter #(
        .DATA_WIDTH(DW),
        .CNT_WIDTH (CW)
    ) dut (
        .ACLK       (ACLK),
        .ARESETn    (ARESETn),
        .TDATA_in_0 (tdata[0]),
        .TVALID_in_0(tvalid[0]),
        .TLAST_in_0 (tlast[0]),
        .TREADY_in_0(TREADY_in_0),
        .TDATA_in_1 (tdata[1]),
        .TVALID_in_1(tvalid[1]),
        .TLAST_in_1 (tlast[1]),
        .TREADY_in_1(TREADY_in_1),
        .DATA_out   (DATA_out),
        .TVALID_out (TVALID_out),
        .TLAST_out  (TLAST_out),
        .TREADY_out (TREADY_out),
        .grant      (grant),
        .pkt_cnt_0  (pkt_cnt_0),
        .pkt_cnt_1  (pkt_cnt_1)
    );

    initial forever #5 ACLK = ~ACLK;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input int n, input int len, input logic [DW-1:0] base,
                                 input int gap_at, input int gap);
        beat_t b;
        for (int i = 0; i < len; i++) begin
            b.data = base + DW'(i);
            b.last = (i == len - 1);
            b.gap  = (i == gap_at) ? gap : 0;
            if (n == 0) begin
                src_q0.push_back(b);
                exp_q0.push_back(b);
            end else begin
                src_q1.push_back(b);
                exp_q1.push_back(b);
            end
        end
    endtask

    // A slave holds its front beat until it sees a handshake, optionally idling first.
    task automatic driveSlave(input int n);
        beat_t b;
        tvalid[n] = 1'b0;
        tlast[n]  = 1'b0;
        tdata[n]  = '0;
        forever begin
            @(posedge ACLK);
            if (acc[n]) begin
                if (n == 0 && src_q0.size() > 0) b = src_q0.pop_front();
                if (n == 1 && src_q1.size() > 0) b = src_q1.pop_front();
                started[n] = 1'b0;
            end
            #1;
            if (!ARESETn || (n == 0 ? src_q0.size() : src_q1.size()) == 0) begin
                started[n] = 1'b0;
                tvalid[n]  = 1'b0;
                tlast[n]   = 1'b0;
            end else begin
                b = (n == 0) ? src_q0[0] : src_q1[0];
                if (!started[n]) begin
                    started[n]  = 1'b1;
                    gap_left[n] = b.gap;
                end
                tdata[n] = b.data;
                tlast[n] = b.last;
                if (gap_left[n] > 0) begin
                    gap_left[n]--;
                    tvalid[n] = 1'b0;
                end else begin
                    tvalid[n] = 1'b1;
                end
            end
        end
    endtask

    initial driveSlave(0);
    initial driveSlave(1);

    // Monitor: compares every cycle against the model and pops the scoreboard on transfers.
    initial begin
        beat_t      b;
        logic [1:0] exp_grant;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                m_owner  = -1;
                m_last   = 1;
                m_cnt[0] = 0;
                m_cnt[1] = 0;
                acc[0]   = 1'b0;
                acc[1]   = 1'b0;
                checkOutput("rst_grant", grant, 0);
                checkOutput("rst_tvalid_out", TVALID_out, 0);
                checkOutput("rst_data_out", DATA_out, 0);
                checkOutput("rst_tready_in_0", TREADY_in_0, 0);
                checkOutput("rst_tready_in_1", TREADY_in_1, 0);
                checkOutput("rst_pkt_cnt_0", pkt_cnt_0, 0);
                checkOutput("rst_pkt_cnt_1", pkt_cnt_1, 0);
            end else begin
                exp_grant = (m_owner == 0) ? 2'b01 : (m_owner == 1) ? 2'b10 : 2'b00;
                checkOutput("grant", grant, exp_grant);
                checkOutput("pkt_cnt_0", pkt_cnt_0, m_cnt[0]);
                checkOutput("pkt_cnt_1", pkt_cnt_1, m_cnt[1]);
                checkOutput("tready_in_0", TREADY_in_0, (m_owner == 0) ? TREADY_out : 1'b0);
                checkOutput("tready_in_1", TREADY_in_1, (m_owner == 1) ? TREADY_out : 1'b0);
                if (m_owner < 0) begin
                    checkOutput("idle_tvalid_out", TVALID_out, 0);
                    checkOutput("idle_tlast_out", TLAST_out, 0);
                    checkOutput("idle_data_out", DATA_out, 0);
                    if (tvalid[0] && tvalid[1]) m_owner = (m_last == 0) ? 1 : 0;
                    else if (tvalid[0])         m_owner = 0;
                    else if (tvalid[1])         m_owner = 1;
                end else begin
                    checkOutput("tvalid_out", TVALID_out, tvalid[m_owner]);
                    checkOutput("tlast_out", TLAST_out, tlast[m_owner]);
                    checkOutput("data_out", DATA_out, tdata[m_owner]);
                    if (tvalid[m_owner] && TREADY_out) begin
                        if ((m_owner == 0 ? exp_q0.size() : exp_q1.size()) == 0) begin
                            checks++;
                            errors++;
                            $display("[TB] FAIL sb_empty: beat 0x%0h from slave %0d, expected none", DATA_out, m_owner);
                        end else begin
                            b = (m_owner == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
                            checkOutput("sb_data", DATA_out, b.data);
                            checkOutput("sb_last", TLAST_out, b.last);
                        end
                        if (tlast[m_owner]) begin
                            m_cnt[m_owner] = (m_cnt[m_owner] + 1) % (1 << CW);
                            m_last  = m_owner;
                            m_owner = -1;
                        end
                    end
                end
                acc[0] = tvalid[0] && TREADY_in_0;
                acc[1] = tvalid[1] && TREADY_in_1;
            end
        end
    end

    task automatic waitIdle(input int max_cycles);
        int n = 0;
        @(posedge ACLK);
        #2;
        while (!(src_q0.size() == 0 && src_q1.size() == 0 && !tvalid[0] && !tvalid[1] && m_owner < 0)) begin
            n++;
            if (n > max_cycles) begin
                checks++;
                errors++;
                $display("[TB] FAIL drain_timeout: still busy after %0d cycles, expected idle", max_cycles);
                return;
            end
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic skipNeg(input int k);
        for (int i = 0; i < k; i++) @(negedge ACLK);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s;
        int len;
        ARESETn    = 1'b1;
        TREADY_out = 1'b0;
        #1 ARESETn = 1'b0;
        #1;
        checkOutput("reset_grant", grant, 0);
        checkOutput("reset_pkt_cnt_1", pkt_cnt_1, 0);
        @(posedge ACLK);
        @(posedge ACLK);
        #3 ARESETn = 1'b1;

        $display("[TB] tie between both slaves, 4-beat packets");
        @(posedge ACLK);
        #1 TREADY_out = 1'b1;
        #1;
        applyStimulus(0, 4, 8'h10, 0, 0);
        applyStimulus(1, 4, 8'h20, 0, 0);
        applyStimulus(0, 4, 8'h30, 0, 0);
        for (int i = 0; i < 17; i++) begin
            @(negedge ACLK);
            checkOutput($sformatf("tie_grant[%0d]", i), grant, TIE_TRACE[i]);
            if (i == 11) begin
                checkOutput("tie_pkt_cnt_0", pkt_cnt_0, 1);
                checkOutput("tie_pkt_cnt_1", pkt_cnt_1, 1);
            end
        end
        waitIdle(100);

        $display("[TB] lock while slave 0 drops TVALID mid-packet");
        @(posedge ACLK);
        #2 applyStimulus(0, 3, 8'h50, 1, 3);
        @(posedge ACLK);
        #2 applyStimulus(1, 1, 8'h60, 0, 0);
        skipNeg(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checkOutput("lock_grant", grant, 2'b01);
            checkOutput("lock_tready_in_1", TREADY_in_1, 0);
            checkOutput("lock_tvalid_out", TVALID_out, 0);
        end
        waitIdle(100);

        $display("[TB] backpressure during slave 1 packet");
        @(posedge ACLK);
        #1 TREADY_out = 1'b0;
        #1 applyStimulus(1, 2, 8'h40, 0, 0);
        skipNeg(2);
        for (int i = 0; i < 5; i++) begin
            @(negedge ACLK);
            checkOutput("bp_grant", grant, 2'b10);
            checkOutput("bp_data_out", DATA_out, 8'h40);
            checkOutput("bp_tready_in_1", TREADY_in_1, 0);
            checkOutput("bp_pkt_cnt_1", pkt_cnt_1, 2);
        end
        @(posedge ACLK);
        #1 TREADY_out = 1'b1;
        waitIdle(100);

        $display("[TB] single-beat packets back to back from slave 0");
        @(posedge ACLK);
        #2;
        applyStimulus(0, 1, 8'hA5, 0, 0);
        applyStimulus(0, 1, 8'hA6, 0, 0);
        for (int i = 0; i < 6; i++) begin
            @(negedge ACLK);
            checkOutput($sformatf("bubble_grant[%0d]", i), grant, BUBBLE_TRACE[i]);
            if (i == 2) begin
                checkOutput("single_data_out", DATA_out, 8'hA5);
                checkOutput("single_tlast_out", TLAST_out, 1);
            end
            if (i == 3) checkOutput("single_pkt_cnt_0", pkt_cnt_0, 4);
            if (i == 4) checkOutput("second_data_out", DATA_out, 8'hA6);
            if (i == 5) checkOutput("second_pkt_cnt_0", pkt_cnt_0, 5);
        end
        waitIdle(100);

        $display("[TB] reset in the middle of a slave 1 packet");
        @(posedge ACLK);
        #2 applyStimulus(1, 4, 8'h70, 0, 0);
        skipNeg(3);
        checkOutput("pre_reset_grant", grant, 2'b10);
        @(posedge ACLK);
        #3;
        ARESETn = 1'b0;
        src_q0.delete();
        src_q1.delete();
        exp_q0.delete();
        exp_q1.delete();
        #1;
        checkOutput("midrst_grant", grant, 0);
        checkOutput("midrst_tready_in_1", TREADY_in_1, 0);
        checkOutput("midrst_tvalid_out", TVALID_out, 0);
        checkOutput("midrst_pkt_cnt_0", pkt_cnt_0, 0);
        checkOutput("midrst_pkt_cnt_1", pkt_cnt_1, 0);
        @(posedge ACLK);
        @(posedge ACLK);
        #3 ARESETn = 1'b1;
        @(posedge ACLK);
        #2;
        applyStimulus(0, 1, 8'h81, 0, 0);
        applyStimulus(1, 1, 8'h91, 0, 0);
        skipNeg(3);
        checkOutput("post_rst_tie_grant", grant, 2'b01);
        checkOutput("post_rst_tie_data", DATA_out, 8'h81);
        skipNeg(2);
        checkOutput("post_rst_second_grant", grant, 2'b10);
        checkOutput("post_rst_second_data", DATA_out, 8'h91);
        waitIdle(100);

        $display("[TB] slave 1 packet counter wrap");
        @(posedge ACLK);
        #2;
        for (int i = 0; i < 255; i++) applyStimulus(1, 1, DW'(i), 0, 0);
        waitIdle(1200);
        checkOutput("wrap_pkt_cnt_1", pkt_cnt_1, 0);
        checkOutput("wrap_pkt_cnt_0", pkt_cnt_0, 1);

        $display("[TB] randomized traffic with random backpressure");
        for (int c = 0; c < 800; c++) begin
            @(posedge ACLK);
            #2;
            TREADY_out = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                s   = $urandom_range(0, 1);
                len = $urandom_range(1, 4);
                if ((s == 0 ? src_q0.size() : src_q1.size()) < 6)
                    applyStimulus(s, len, DW'($urandom), $urandom_range(0, len - 1), $urandom_range(0, 2));
            end
        end
        @(posedge ACLK);
        #2 TREADY_out = 1'b1;
        waitIdle(2000);
        checkOutput("drain_exp_q0", exp_q0.size(), 0);
        checkOutput("drain_exp_q1", exp_q1.size(), 0);
        checkOutput("final_pkt_cnt_0", pkt_cnt_0, m_cnt[0]);
        checkOutput("final_pkt_cnt_1", pkt_cnt_1, m_cnt[1]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
